pipeline_ctrl: RTL

Central sequencer for the five-stage pipeline. Each cycle it computes the write-enable (`*W`) and flush (`*RST`) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches, based on cache hits, load-use hazards, taken branches and halt. It also owns the HALTED state, a data-stall watchdog and saturating performance counters. It sits beside the datapath, and its outputs drive the latch enable/flush pins directly.

---
 rtl/pipeline_ctrl_if.sv | 20 ++
 rtl/pipeline_ctrl.sv | 70 +++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: datapath <-> pipeline sequencer signal bundle
// master: datapath side, drives hit/hazard/halt status, receives latch controls and counters
// slave:  pipeline_ctrl side, receives status, drives pcW, *W/*RST, halt, dwdog_err, counters
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
   logic             ihit, dhit, memREN, memWEN, memValid, memBranchTaken, exMemRead, wbcuHALT;
   logic [4:0]       exRd, idRs, idRt;
   logic             pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST, memwbW, memwbRST;
   logic             halt, dwdog_err;
   logic [CNT_W-1:0] cyc_cnt, instr_cnt, stall_cnt, flush_cnt;
   modport master (
      output ihit, dhit, memREN, memWEN, memValid, memBranchTaken, exMemRead, wbcuHALT, exRd, idRs, idRt,
      input  pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST, memwbW, memwbRST, halt, dwdog_err,
             cyc_cnt, instr_cnt, stall_cnt, flush_cnt
   );
   modport slave (
      input  ihit, dhit, memREN, memWEN, memValid, memBranchTaken, exMemRead, wbcuHALT, exRd, idRs, idRt,
      output pcW, ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST, memwbW, memwbRST, halt, dwdog_err,
             cyc_cnt, instr_cnt, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: five-stage pipeline sequencer (latch enables/flushes, halt, data-stall watchdog, perf counters)
// CLK, nRST (async, active-low); bus_io: slave view of pipeline_ctrl_if
module pipeline_ctrl #(
   parameter int CNT_W    = 32,
   parameter int DTIMEOUT = 1024
) (
   input logic            CLK,
   input logic            nRST,
   pipeline_ctrl_if.slave bus_io
);
   localparam int DW = $clog2(DTIMEOUT);
   typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;
   state_t           state_q, state_d;
   logic [DW-1:0]    dcnt_q, dcnt_d;
   logic             err_q, halted, dwait, lu, dtop;
   logic [CNT_W-1:0] cyc_q, instr_q, stall_q, flush_q;
   logic [4:0]       w;
   logic [3:0]       r;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && !(&v)) ? v + CNT_W'(1) : v;
   endfunction
   assign halted = state_q == HALTED;
   assign dwait  = (bus_io.memREN | bus_io.memWEN) & ~bus_io.dhit;
   assign lu     = bus_io.exMemRead & (|bus_io.exRd) &
                   (bus_io.exRd == bus_io.idRs | bus_io.exRd == bus_io.idRt);
   assign dtop   = dcnt_q == DW'(DTIMEOUT - 1);
   // w = {pc, ifid, idex, exmem, memwb}, r = {ifid, idex, exmem, memwb}
   always_comb begin
      w = 5'b11111;
      r = 4'b0000;
      if (halted || bus_io.wbcuHALT) w = 5'b00000;
      else if (dwait) begin w = 5'b00001; r = 4'b0001; end
      else if (bus_io.memBranchTaken) r = 4'b1110;
      else if (lu) begin w = 5'b00111; r = 4'b0100; end
      else if (!bus_io.ihit) begin w = 5'b01111; r = 4'b1000; end
   end
   assign state_d = (halted || bus_io.wbcuHALT) ? HALTED : dwait ? DWAIT : RUN;
   // saturate at the top so a very long stall cannot wrap back below the threshold
   assign dcnt_d  = !dwait ? '0 : dtop ? dcnt_q : dcnt_q + DW'(1);
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
         dcnt_q  <= '0;
         err_q   <= 1'b0;
         cyc_q   <= '0;
         instr_q <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         err_q   <= err_q | (dwait & dtop);
         if (!halted) begin
            cyc_q   <= sat_inc(cyc_q, 1'b1);
            instr_q <= sat_inc(instr_q, w[0] & ~r[0] & bus_io.memValid);
            // pcW low with some latch still enabled isolates the stall rules from halt
            stall_q <= sat_inc(stall_q, ~w[4] & (|w));
            flush_q <= sat_inc(flush_q, r[3] & r[2]);
         end
      end
   end
   assign {bus_io.pcW, bus_io.ifidW, bus_io.idexW, bus_io.exmemW, bus_io.memwbW} = w;
   assign {bus_io.ifidRST, bus_io.idexRST, bus_io.exmemRST, bus_io.memwbRST} = r;
   assign bus_io.halt      = halted;
   assign bus_io.dwdog_err = err_q;
   assign bus_io.cyc_cnt   = cyc_q;
   assign bus_io.instr_cnt = instr_q;
   assign bus_io.stall_cnt = stall_q;
   assign bus_io.flush_cnt = flush_q;
endmodule
